// File: rtl/counter_seq_ctrl.sv
// ---------------------------------------------------------------------------
// counter_seq_ctrl
//   Sequencer for a WIDTH-bit synchronous up-counter. It clears the counter,
//   enables it until its count reaches a terminal value latched with start,
//   and then reports completion. In one-shot mode it parks in DONE with the
//   counter holding the terminal value. In periodic mode it clears and
//   restarts automatically after every completed period.
//
// Ports
//   clk         in   1       clock, all state changes on posedge
//   rst         in   1       asynchronous active-high reset
//   start       in   1       start request (accepted in IDLE/DONE only)
//   stop        in   1       abort, highest priority
//   hold        in   1       freeze counting while high (RUN only)
//   periodic    in   1       mode sampled with start: 1 auto-restart
//   load_val    in   WIDTH   terminal count sampled with start (0 rejected)
//   cnt_val     in   WIDTH   counter's present count
//   cnt_en      out  1       counter enable (combinational)
//   cnt_clr     out  1       counter synchronous clear (combinational)
//   busy        out  1       high in CLR or RUN
//   done        out  1       1-cycle pulse per completed period
//   err         out  1       1-cycle pulse on rejected start or overrun
//   status      out  2       00 IDLE, 01 CLR, 10 RUN, 11 DONE
//   period_cnt  out  PCNT_W  completed periods since last accepted start
// ---------------------------------------------------------------------------
module counter_seq_ctrl #(
  parameter int WIDTH  = 4,
  parameter int PCNT_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic              hold,
  input  logic              periodic,
  input  logic [WIDTH-1:0]  load_val,
  input  logic [WIDTH-1:0]  cnt_val,
  output logic              cnt_en,
  output logic              cnt_clr,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [1:0]        status,
  output logic [PCNT_W-1:0] period_cnt
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_CLR  = 2'b01,
    S_RUN  = 2'b10,
    S_DONE = 2'b11
  } state_t;

  state_t              r_state;
  logic [WIDTH-1:0]    r_term;
  logic                r_mode;
  logic [PCNT_W-1:0]   r_period_cnt;
  logic                r_done;
  logic                r_err;

  logic                w_hit;
  logic                w_over;
  logic                w_load_ok;

  assign w_hit     = (cnt_val == r_term);
  assign w_over    = (cnt_val > r_term);
  assign w_load_ok = (load_val != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_term       <= '0;
      r_mode       <= 1'b0;
      r_period_cnt <= '0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      // done/err are single-cycle pulses unless re-raised below
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE: begin
          if (stop) begin
            // stop outranks start; from IDLE it simply has no effect
            r_state <= S_IDLE;
          end else if (start) begin
            if (w_load_ok) begin
              r_term       <= load_val;
              r_mode       <= periodic;
              r_period_cnt <= '0;
              r_state      <= S_CLR;
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        S_CLR: begin
          r_state <= stop ? S_IDLE : S_RUN;
        end
        S_RUN: begin
          if (stop) begin
            r_state <= S_IDLE;
          end else if (w_hit) begin
            // terminal hit counts even while hold is high: hold only
            // freezes the counter, it does not mask completion
            r_done       <= 1'b1;
            r_period_cnt <= r_period_cnt + 1'b1;
            r_state      <= r_mode ? S_CLR : S_DONE;
          end else if (w_over) begin
            r_err   <= 1'b1;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    cnt_en  = 1'b0;
    cnt_clr = 1'b0;
    busy    = 1'b0;
    case (r_state)
      S_CLR: begin
        cnt_clr = 1'b1;
        busy    = 1'b1;
      end
      S_RUN: begin
        // stop kills the enable in the same cycle it is seen
        cnt_en = !hold && !stop && !w_hit;
        busy   = 1'b1;
      end
      default: ;
    endcase
  end

  assign done       = r_done;
  assign err        = r_err;
  assign status     = r_state;
  assign period_cnt = r_period_cnt;

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_counter_seq_ctrl
//   Directed bench for counter_seq_ctrl. A behavioural 4-bit up-counter is
//   wired to cnt_en/cnt_clr and fed back on cnt_val; a force path can
//   override cnt_val to create an overrun.
// ---------------------------------------------------------------------------
module tb_counter_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       stop;
  logic       hold;
  logic       periodic;
  logic [3:0] load_val;
  logic [3:0] cnt_val;
  logic       cnt_en;
  logic       cnt_clr;
  logic       busy;
  logic       done;
  logic       err;
  logic [1:0] status;
  logic [7:0] period_cnt;

  logic [3:0] r_cnt;
  logic       frc;
  logic [3:0] frc_val;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // counter under control of the sequencer
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          r_cnt <= '0;
    else if (cnt_clr) r_cnt <= '0;
    else if (cnt_en)  r_cnt <= r_cnt + 4'd1;
  end

  assign cnt_val = frc ? frc_val : r_cnt;

  counter_seq_ctrl #(.WIDTH(4), .PCNT_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .stop       (stop),
    .hold       (hold),
    .periodic   (periodic),
    .load_val   (load_val),
    .cnt_val    (cnt_val),
    .cnt_en     (cnt_en),
    .cnt_clr    (cnt_clr),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .status     (status),
    .period_cnt (period_cnt)
  );

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // drive start for one edge (E0), then release
  task automatic do_start(input logic [3:0] lv, input logic per);
    start    = 1'b1;
    load_val = lv;
    periodic = per;
    tick(1);
    start    = 1'b0;
    load_val = 4'd0;
    periodic = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; hold = 1'b0; periodic = 1'b0;
    load_val = 4'd0; frc = 1'b0; frc_val = 4'd0;
    tick(2);
    chk("rst_status", status, 2'b00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_cnt_en", cnt_en, 1'b0);
    chk("rst_cnt_clr", cnt_clr, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_pcnt", period_cnt, 8'd0);
    rst = 1'b0;
    tick(1);

    // ---- one-shot T=4: done at E6 ----
    do_start(4'd4, 1'b0);                       // E0
    chk("os_clr_status", status, 2'b01);
    chk("os_clr_pulse", cnt_clr, 1'b1);
    chk("os_clr_en", cnt_en, 1'b0);
    chk("os_clr_busy", busy, 1'b1);
    tick(1);                                    // E1
    chk("os_run_status", status, 2'b10);
    chk("os_run_cnt0", cnt_val, 4'd0);
    chk("os_run_en", cnt_en, 1'b1);
    chk("os_run_clr", cnt_clr, 1'b0);
    tick(4);                                    // E5
    chk("os_e5_cnt", cnt_val, 4'd4);
    chk("os_e5_done", done, 1'b0);
    chk("os_e5_en", cnt_en, 1'b0);
    tick(1);                                    // E6
    chk("os_e6_done", done, 1'b1);
    chk("os_e6_status", status, 2'b11);
    chk("os_e6_busy", busy, 1'b0);
    chk("os_e6_pcnt", period_cnt, 8'd1);
    chk("os_e6_cnt", cnt_val, 4'd4);
    tick(1);
    chk("os_done_pulse_end", done, 1'b0);
    chk("os_hold_term", cnt_val, 4'd4);
    chk("os_stay_done", status, 2'b11);
    stop = 1'b1;
    tick(1);
    stop = 1'b0;
    chk("os_stop_idle", status, 2'b00);

    // ---- reject start with load_val=0 ----
    do_start(4'd0, 1'b0);
    chk("rej0_err", err, 1'b1);
    chk("rej0_status", status, 2'b00);
    tick(1);
    chk("rej0_err_end", err, 1'b0);

    // ---- periodic T=3: done every 5 cycles ----
    do_start(4'd3, 1'b1);                       // E0
    tick(1);                                    // E1
    chk("per_cnt0", cnt_val, 4'd0);
    tick(3);                                    // E4
    chk("per_e4_cnt", cnt_val, 4'd3);
    chk("per_e4_done", done, 1'b0);
    tick(1);                                    // E5
    chk("per_e5_done", done, 1'b1);
    chk("per_e5_status", status, 2'b01);
    chk("per_e5_clr", cnt_clr, 1'b1);
    chk("per_e5_pcnt", period_cnt, 8'd1);
    for (int p = 2; p <= 3; p++) begin
      tick(1);
      chk("per_restart_cnt", cnt_val, 4'd0);
      chk("per_restart_done", done, 1'b0);
      tick(3);
      chk("per_pre_cnt", cnt_val, 4'd3);
      chk("per_pre_done", done, 1'b0);
      tick(1);
      chk("per_done", done, 1'b1);
      chk("per_pcnt", period_cnt, p[7:0]);
    end
    tick(1);                                    // RUN, count 0
    chk("per_run_en", cnt_en, 1'b1);
    stop = 1'b1;
    #1;
    chk("per_stop_en_now", cnt_en, 1'b0);
    tick(1);
    stop = 1'b0;
    chk("per_stop_status", status, 2'b00);
    chk("per_stop_busy", busy, 1'b0);
    chk("per_stop_done", done, 1'b0);
    chk("per_stop_pcnt", period_cnt, 8'd3);

    // ---- hold: T=5, hold 3 cycles at count 2, done at E10 ----
    do_start(4'd5, 1'b0);                       // E0
    tick(3);                                    // E3
    chk("hold_cnt2", cnt_val, 4'd2);
    hold = 1'b1;
    #1;
    chk("hold_en_off", cnt_en, 1'b0);
    tick(3);                                    // E6
    chk("hold_frozen", cnt_val, 4'd2);
    chk("hold_status", status, 2'b10);
    chk("hold_no_done", done, 1'b0);
    hold = 1'b0;
    tick(1);                                    // E7
    chk("hold_e7_done", done, 1'b0);
    tick(2);                                    // E9
    chk("hold_e9_cnt", cnt_val, 4'd5);
    chk("hold_e9_done", done, 1'b0);
    tick(1);                                    // E10
    chk("hold_e10_done", done, 1'b1);
    chk("hold_e10_status", status, 2'b11);

    // ---- start from DONE, then start while RUN ignored ----
    do_start(4'd4, 1'b0);                       // E0
    chk("busy_clr_status", status, 2'b01);
    chk("busy_pcnt_reset", period_cnt, 8'd0);
    tick(2);                                    // E2
    start = 1'b1; load_val = 4'd9;
    tick(1);                                    // E3
    start = 1'b0; load_val = 4'd0;
    chk("busy_ign_err", err, 1'b0);
    chk("busy_ign_cnt", cnt_val, 4'd2);
    chk("busy_ign_status", status, 2'b10);
    tick(2);                                    // E5
    chk("busy_e5_cnt", cnt_val, 4'd4);
    chk("busy_e5_done", done, 1'b0);
    tick(1);                                    // E6
    chk("busy_e6_done", done, 1'b1);
    chk("busy_e6_status", status, 2'b11);

    // ---- stop coinciding with terminal hit ----
    do_start(4'd4, 1'b0);                       // E0
    tick(5);                                    // E5
    chk("col_cnt", cnt_val, 4'd4);
    stop = 1'b1;
    tick(1);                                    // E6
    stop = 1'b0;
    chk("col_status", status, 2'b00);
    chk("col_no_done", done, 1'b0);
    chk("col_pcnt", period_cnt, 8'd0);

    // ---- overrun: forced cnt_val=7 with T=4 ----
    do_start(4'd4, 1'b0);                       // E0
    tick(2);                                    // E2
    frc = 1'b1; frc_val = 4'd7;
    tick(1);                                    // E3
    chk("ovr_err", err, 1'b1);
    chk("ovr_status", status, 2'b00);
    chk("ovr_no_done", done, 1'b0);
    frc = 1'b0;
    tick(1);
    chk("ovr_err_end", err, 1'b0);

    // ---- async reset mid-RUN, then fresh start T=2 ----
    do_start(4'd4, 1'b0);                       // E0
    tick(3);                                    // E3
    chk("ar_cnt2", cnt_val, 4'd2);
    #2;
    rst = 1'b1;
    #1;
    chk("ar_status", status, 2'b00);
    chk("ar_busy", busy, 1'b0);
    chk("ar_cnt_en", cnt_en, 1'b0);
    chk("ar_cnt_clr", cnt_clr, 1'b0);
    chk("ar_pcnt", period_cnt, 8'd0);
    #1;
    rst = 1'b0;
    tick(1);
    do_start(4'd2, 1'b0);                       // E0
    tick(3);                                    // E3
    chk("ar_e3_cnt", cnt_val, 4'd2);
    chk("ar_e3_done", done, 1'b0);
    tick(1);                                    // E4
    chk("ar_e4_done", done, 1'b1);
    chk("ar_e4_status", status, 2'b11);
    chk("ar_e4_pcnt", period_cnt, 8'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
